// File: rtl/uart_pkg.sv
// Shared constants for the UART receiver: parity modes, FSM encoding and FIFO entry width.
package uart_pkg;

  localparam int unsigned PARITY_NONE = 0;
  localparam int unsigned PARITY_ODD  = 1;
  localparam int unsigned PARITY_EVEN = 2;

  // Entry layout: {data[7:0], perr, ferr}
  localparam int unsigned ENTRY_W = 8 + 2;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } rx_state_e;

endpackage

// File: rtl/uart_fifo.sv
// First-word-fall-through receive FIFO; pointers carry one extra bit to tell full from empty.
module uart_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic               clock25,
  input  logic               reset_n,
  input  logic               i_push,
  input  logic [ENTRY_W-1:0] i_data,
  input  logic               i_pop,
  output logic [ENTRY_W-1:0] o_data,
  output logic               o_full,
  output logic               o_empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [ENTRY_W-1:0] r_mem [DEPTH];
  logic [AW:0]        r_wptr;
  logic [AW:0]        r_rptr;
  logic               w_wr;
  logic               w_rd;

  assign o_empty = (r_wptr == r_rptr);
  assign o_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_rd    = i_pop && !o_empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign w_wr    = i_push && (!o_full || w_rd);

  always_ff @(posedge clock25 or negedge reset_n) begin
    if (!reset_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_wr) r_wptr <= r_wptr + 1'b1;
      if (w_rd) r_rptr <= r_rptr + 1'b1;
    end
  end

  always_ff @(posedge clock25) begin
    if (w_wr) r_mem[r_wptr[AW-1:0]] <= i_data;
  end

  assign o_data = o_empty ? '0 : r_mem[r_rptr[AW-1:0]];

endmodule

// File: rtl/uart_rx.sv
// Parametrised UART receiver: synchroniser, start-glitch rejection, parity/framing checks,
// and a FWFT receive FIFO with valid/ready pop and overrun pulse.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned DIVISOR   = 54,
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned PARITY    = 0,
  parameter int unsigned STOP_BITS = 1,
  parameter int unsigned DEPTH     = 4
) (
  input  logic       clock25,
  input  logic       reset_n,
  input  logic       rx,
  output logic [7:0] out_data,
  output logic       out_perr,
  output logic       out_ferr,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       overrun,
  output logic       busy
);

  localparam int unsigned CntW = $clog2(DIVISOR);
  // START samples DIVISOR/2 edges after entry; later samples every DIVISOR edges.
  localparam logic [CntW-1:0] HalfM1 = CntW'(DIVISOR / 2 - 1);
  localparam logic [CntW-1:0] FullM1 = CntW'(DIVISOR - 1);

  rx_state_e          r_state;
  rx_state_e          w_state_next;
  logic               r_sync1, r_sync2, r_prev;
  logic [CntW-1:0]    r_cnt;
  logic [2:0]         r_idx;
  logic [7:0]         r_shift;
  logic               r_par, r_perr, r_ferr, r_overrun;
  logic               w_line, w_fall, w_tick, w_last_data, w_last_stop;
  logic               w_push, w_pop, w_full, w_empty, w_par_exp;
  logic [7:0]         w_data;
  logic [ENTRY_W-1:0] w_entry, w_head;

  always_ff @(posedge clock25 or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_prev  <= 1'b1;
    end else begin
      r_sync1 <= rx;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  assign w_line      = r_sync2;
  assign w_fall      = r_prev & ~r_sync2;
  assign w_tick      = (r_state == StStart) ? (r_cnt == HalfM1) : (r_cnt == FullM1);
  assign w_last_data = (r_idx == 3'(DATA_BITS - 1));
  assign w_last_stop = (r_idx == 3'(STOP_BITS - 1));
  assign w_par_exp   = (PARITY == PARITY_ODD) ? ~r_par : r_par;

  always_ff @(posedge clock25 or negedge reset_n) begin
    if (!reset_n) r_state <= StIdle;
    else          r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:   if (w_fall) w_state_next = StStart;
      StStart:  if (w_tick) w_state_next = w_line ? StIdle : StData;
      StData:   if (w_tick && w_last_data) begin
        w_state_next = (PARITY != PARITY_NONE) ? StParity : StStop;
      end
      StParity: if (w_tick) w_state_next = StStop;
      StStop:   if (w_tick && w_last_stop) w_state_next = StIdle;
      default:  w_state_next = StIdle;
    endcase
  end

  always_comb begin
    busy   = (r_state != StIdle);
    w_push = (r_state == StStop) && w_tick && w_last_stop;
  end

  always_ff @(posedge clock25 or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
      r_par   <= 1'b0;
      r_perr  <= 1'b0;
      r_ferr  <= 1'b0;
    end else if (r_state == StIdle) begin
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
      r_par   <= 1'b0;
      r_perr  <= 1'b0;
      r_ferr  <= 1'b0;
    end else if (w_tick) begin
      r_cnt <= '0;
      r_idx <= ((r_state == StData && !w_last_data) || (r_state == StStop && !w_last_stop)) ?
               r_idx + 3'd1 : 3'd0;
      if (r_state == StData) begin
        r_shift <= {w_line, r_shift[7:1]};
        r_par   <= r_par ^ w_line;
      end
      if (r_state == StParity) r_perr <= (w_line != w_par_exp);
      if (r_state == StStop && !w_line) r_ferr <= 1'b1;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Bits enter at the top; right-align for frames narrower than a byte.
  assign w_data  = r_shift >> (8 - DATA_BITS);
  assign w_entry = {w_data, r_perr, r_ferr | ~w_line};
  assign w_pop   = out_ready && out_valid;

  uart_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock25 (clock25),
    .reset_n (reset_n),
    .i_push  (w_push),
    .i_data  (w_entry),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge clock25 or negedge reset_n) begin
    if (!reset_n) r_overrun <= 1'b0;
    else          r_overrun <= w_push && w_full && !w_pop;
  end

  assign out_data  = w_head[9:2];
  assign out_perr  = w_head[1];
  assign out_ferr  = w_head[0];
  assign out_valid = !w_empty;
  assign overrun   = r_overrun;

endmodule

// File: tb/tb_uart_rx.sv
// Directed and randomised checks of uart_rx across four configurations (8N1, 7E1, 8N2, 6O2).
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx_a    [4];
  logic       ready_a [4];
  logic [7:0] data_a  [4];
  logic       perr_a  [4];
  logic       ferr_a  [4];
  logic       valid_a [4];
  logic       ovr_a   [4];
  logic       busy_a  [4];

  int total = 0;
  int bad   = 0;
  int ovr_cnt = 0;
  logic mon_en = 1'b0;
  logic [7:0] got [$];

  always #5 clk = ~clk;

  uart_rx #(.DIVISOR(54), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .DEPTH(4)) u_8n1 (
    .clock25(clk), .reset_n(rst_n), .rx(rx_a[0]), .out_data(data_a[0]), .out_perr(perr_a[0]),
    .out_ferr(ferr_a[0]), .out_valid(valid_a[0]), .out_ready(ready_a[0]), .overrun(ovr_a[0]),
    .busy(busy_a[0]));

  uart_rx #(.DIVISOR(16), .DATA_BITS(7), .PARITY(2), .STOP_BITS(1), .DEPTH(4)) u_7e1 (
    .clock25(clk), .reset_n(rst_n), .rx(rx_a[1]), .out_data(data_a[1]), .out_perr(perr_a[1]),
    .out_ferr(ferr_a[1]), .out_valid(valid_a[1]), .out_ready(ready_a[1]), .overrun(ovr_a[1]),
    .busy(busy_a[1]));

  uart_rx #(.DIVISOR(16), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2), .DEPTH(4)) u_8n2 (
    .clock25(clk), .reset_n(rst_n), .rx(rx_a[2]), .out_data(data_a[2]), .out_perr(perr_a[2]),
    .out_ferr(ferr_a[2]), .out_valid(valid_a[2]), .out_ready(ready_a[2]), .overrun(ovr_a[2]),
    .busy(busy_a[2]));

  uart_rx #(.DIVISOR(12), .DATA_BITS(6), .PARITY(1), .STOP_BITS(2), .DEPTH(8)) u_6o2 (
    .clock25(clk), .reset_n(rst_n), .rx(rx_a[3]), .out_data(data_a[3]), .out_perr(perr_a[3]),
    .out_ferr(ferr_a[3]), .out_valid(valid_a[3]), .out_ready(ready_a[3]), .overrun(ovr_a[3]),
    .busy(busy_a[3]));

  always @(negedge clk) begin
    if (ovr_a[0]) ovr_cnt++;
    if (mon_en && valid_a[0] && ready_a[0]) got.push_back(data_a[0]);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Frame bits in line order: start, data LSB-first, optional parity, stop bit(s).
  function automatic logic [15:0] mkframe(input logic [7:0] d, input int nb, input bit haspar,
                                          input logic p, input logic s1, input logic s2,
                                          input int nstop, output int len);
    logic [15:0] f;
    int n;
    f = '1;
    n = 0;
    f[n] = 1'b0;
    n++;
    for (int i = 0; i < nb; i++) begin
      f[n] = d[i];
      n++;
    end
    if (haspar) begin
      f[n] = p;
      n++;
    end
    f[n] = s1;
    n++;
    if (nstop == 2) begin
      f[n] = s2;
      n++;
    end
    len = n;
    return f;
  endfunction

  task automatic send(input int u, input logic [15:0] f, input int nsend, input int div);
    for (int i = 0; i < nsend; i++) begin
      rx_a[u] = f[i];
      repeat (div) @(negedge clk);
    end
    rx_a[u] = 1'b1;
  endtask

  task automatic pop(input int u);
    ready_a[u] = 1'b1;
    @(negedge clk);
    ready_a[u] = 1'b0;
  endtask

  initial begin
    logic [15:0] f;
    int len;
    int ovr0;
    int got0;
    logic [7:0] d;
    logic p, s1, s2;
    logic [9:0] exp_q [$];
    logic [9:0] e;

    rst_n = 1'b0;
    for (int u = 0; u < 4; u++) begin
      rx_a[u] = 1'b1;
      ready_a[u] = 1'b0;
    end
    repeat (3) @(negedge clk);
    for (int u = 0; u < 4; u++) begin
      chk($sformatf("rst_valid%0d", u), 32'(valid_a[u]), 0);
      chk($sformatf("rst_busy%0d", u), 32'(busy_a[u]), 0);
      chk($sformatf("rst_data%0d", u), 32'(data_a[u]), 0);
      chk($sformatf("rst_ovr%0d", u), 32'(ovr_a[u]), 0);
    end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // 8N1 latency: valid appears 515 edges after the first low sample
    f = mkframe(8'hA5, 8, 0, 1'b0, 1'b1, 1'b1, 1, len);
    for (int c = 0; c < 10 * 54; c++) begin
      rx_a[0] = f[c / 54];
      @(negedge clk);
      if (c == 514) chk("lat_before", 32'(valid_a[0]), 0);
      if (c == 515) chk("lat_at", 32'(valid_a[0]), 1);
    end
    rx_a[0] = 1'b1;
    chk("a5_data", 32'(data_a[0]), 32'hA5);
    chk("a5_perr", 32'(perr_a[0]), 0);
    chk("a5_ferr", 32'(ferr_a[0]), 0);
    pop(0);
    chk("a5_empty", 32'(valid_a[0]), 0);

    // 7E1 parity
    f = mkframe(8'h41, 7, 1, ~(^7'h41), 1'b1, 1'b1, 1, len);
    send(1, f, len, 16);
    chk("7e1_bad_valid", 32'(valid_a[1]), 1);
    chk("7e1_bad_data", 32'(data_a[1]), 32'h41);
    chk("7e1_bad_perr", 32'(perr_a[1]), 1);
    chk("7e1_bad_ferr", 32'(ferr_a[1]), 0);
    pop(1);
    f = mkframe(8'h41, 7, 1, ^7'h41, 1'b1, 1'b1, 1, len);
    send(1, f, len, 16);
    chk("7e1_ok_data", 32'(data_a[1]), 32'h41);
    chk("7e1_ok_perr", 32'(perr_a[1]), 0);
    pop(1);
    chk("7e1_empty", 32'(valid_a[1]), 0);

    // 8N2 framing error on second stop bit, then a break
    f = mkframe(8'h3C, 8, 0, 1'b0, 1'b1, 1'b0, 2, len);
    send(2, f, len, 16);
    repeat (4) @(negedge clk);
    chk("8n2_data", 32'(data_a[2]), 32'h3C);
    chk("8n2_ferr", 32'(ferr_a[2]), 1);
    pop(2);
    chk("8n2_one_entry", 32'(valid_a[2]), 0);
    rx_a[2] = 1'b0;
    repeat (20 * 16) @(negedge clk);
    chk("brk_valid", 32'(valid_a[2]), 1);
    chk("brk_data", 32'(data_a[2]), 0);
    chk("brk_ferr", 32'(ferr_a[2]), 1);
    chk("brk_busy", 32'(busy_a[2]), 0);
    pop(2);
    repeat (100) @(negedge clk);
    chk("brk_no_more", 32'(valid_a[2]), 0);
    rx_a[2] = 1'b1;
    repeat (50) @(negedge clk);
    chk("brk_high_valid", 32'(valid_a[2]), 0);
    chk("brk_high_busy", 32'(busy_a[2]), 0);

    // Start-bit glitch on 8N1
    rx_a[0] = 1'b0;
    repeat (10) @(negedge clk);
    rx_a[0] = 1'b1;
    chk("gl_busy", 32'(busy_a[0]), 1);
    repeat (20) @(negedge clk);
    chk("gl_idle", 32'(busy_a[0]), 0);
    repeat (600) @(negedge clk);
    chk("gl_noentry", 32'(valid_a[0]), 0);

    // Overrun: five frames into a 4-deep FIFO
    ovr0 = ovr_cnt;
    for (int i = 1; i <= 5; i++) begin
      f = mkframe(8'(i), 8, 0, 1'b0, 1'b1, 1'b1, 1, len);
      send(0, f, len, 54);
    end
    repeat (4) @(negedge clk);
    chk("ovr_pulses", 32'(ovr_cnt - ovr0), 1);
    for (int i = 1; i <= 4; i++) begin
      chk($sformatf("ovr_valid%0d", i), 32'(valid_a[0]), 1);
      chk($sformatf("ovr_data%0d", i), 32'(data_a[0]), 32'(i));
      pop(0);
    end
    chk("ovr_drained", 32'(valid_a[0]), 0);

    // Random 6O2 frames against a rule-based model
    for (int i = 0; i < 8; i++) begin
      d  = 8'($urandom_range(0, 63));
      p  = 1'($urandom_range(0, 1));
      s1 = ($urandom_range(0, 3) != 0);
      s2 = ($urandom_range(0, 3) != 0);
      // odd parity: data ones plus parity bit must be odd
      exp_q.push_back({d, ~((^d[5:0]) ^ p), ~(s1 & s2)});
      f = mkframe(d, 6, 1, p, s1, s2, 2, len);
      send(3, f, len, 12);
      repeat ($urandom_range(2, 30)) @(negedge clk);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("rnd_valid", 32'(valid_a[3]), 1);
      chk("rnd_data", 32'(data_a[3]), 32'(e[9:2]));
      chk("rnd_perr", 32'(perr_a[3]), 32'(e[1]));
      chk("rnd_ferr", 32'(ferr_a[3]), 32'(e[0]));
      pop(3);
    end
    chk("rnd_empty", 32'(valid_a[3]), 0);

    // Back-to-back with ready high, reset in the middle of the second frame
    got0 = got.size();
    ready_a[0] = 1'b1;
    mon_en = 1'b1;
    f = mkframe(8'h5A, 8, 0, 1'b0, 1'b1, 1'b1, 1, len);
    send(0, f, len, 54);
    f = mkframe(8'hC3, 8, 0, 1'b0, 1'b1, 1'b1, 1, len);
    send(0, f, 5, 54);
    rst_n = 1'b0;
    rx_a[0] = 1'b1;
    #1;
    chk("mr_busy", 32'(busy_a[0]), 0);
    chk("mr_valid", 32'(valid_a[0]), 0);
    chk("mr_data", 32'(data_a[0]), 0);
    chk("mr_perr", 32'(perr_a[0]), 0);
    chk("mr_ferr", 32'(ferr_a[0]), 0);
    chk("mr_ovr", 32'(ovr_a[0]), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (1200) @(negedge clk);
    mon_en = 1'b0;
    chk("mr_count", 32'(got.size() - got0), 1);
    if (got.size() > got0) chk("mr_first", 32'(got[got0]), 32'h5A);
    chk("mr_after_valid", 32'(valid_a[0]), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
